// File: rtl/uart_pkg.sv
// Shared constants for the UART receiver: FSM state encoding and
// default frame/timing parameters.
package uart_pkg;

  localparam int DBIT_DEF    = 8;    // data bits per frame
  localparam int SB_TICK_DEF = 16;   // oversample ticks spent in the stop bit
  localparam int DVSR_DEF    = 163;  // clk cycles per oversample tick

  // Receiver FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO, first-word-fall-through. The head byte is presented on
// r_data whenever the FIFO is non-empty (0 when empty). A write while full
// is dropped and reported with a one-cycle overrun pulse unless a read
// frees a slot on the same edge.
module uart_rx_fifo #(
  parameter int DBIT   = 8,
  parameter int FIFO_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [DBIT-1:0] w_data,
  input  logic            rd,
  output logic [DBIT-1:0] r_data,
  output logic            empty,
  output logic            full,
  output logic            overrun
);

  localparam int DEPTH = 2 ** FIFO_W;

  logic [DBIT-1:0]   mem [0:DEPTH-1];
  logic [FIFO_W-1:0] wr_ptr_reg;
  logic [FIFO_W-1:0] rd_ptr_reg;
  logic [FIFO_W:0]   count_reg;
  logic              overrun_reg;
  logic              rd_ok;
  logic              wr_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (FIFO_W+1)'(DEPTH));
  assign rd_ok   = rd & ~empty;
  // A simultaneous read makes room, so a write into a full FIFO still lands.
  assign wr_ok   = wr & (~full | rd_ok);
  assign r_data  = empty ? '0 : mem[rd_ptr_reg];
  assign overrun = overrun_reg;

  // Storage array; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr_reg] <= w_data;
  end

  // Pointers, occupancy count and overrun pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      overrun_reg <= wr & full & ~rd_ok;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampling tick generator, rx synchronizer, frame FSM
// and a receive FIFO (uart_rx_fifo).
// Optional even-parity bit support is enabled by defining UART_RX_PARITY_EN;
// without it frames are 8N1-style and parity_err is held at 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int DVSR    = DVSR_DEF,
  parameter int FIFO_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            rd_uart,
  output logic [DBIT-1:0] r_data,
  output logic            rx_empty,
  output logic            rx_full,
  output logic            frame_err,
  output logic            overrun,
  output logic            parity_err
);

  localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

  logic [CW-1:0]   div_reg;
  logic            tick;
  logic            rx_meta_reg;
  logic            rx_sync_reg;
  logic [2:0]      state_reg, state_next;
  logic [3:0]      s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            done;
  logic            ferr_next;
  logic            frame_err_reg;

  assign tick      = (div_reg == CW'(DVSR - 1));
  assign frame_err = frame_err_reg;

  // Free-running divider producing one oversample tick every DVSR clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      div_reg <= '0;
    else if (tick)
      div_reg <= '0;
    else
      div_reg <= div_reg + 1'b1;
  end

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad_reg, par_bad_next;
  logic perr_next;
  logic parity_err_reg;

  // Parity mismatch flag and its reporting pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bad_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      par_bad_reg    <= par_bad_next;
      parity_err_reg <= perr_next;
    end
  end

  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

  // FSM state, counters, shift register and frame-error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      s_reg         <= '0;
      n_reg         <= '0;
      b_reg         <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      s_reg         <= s_next;
      n_reg         <= n_next;
      b_reg         <= b_next;
      frame_err_reg <= ferr_next;
    end
  end

  // Frame FSM: centre-samples each bit using the 16x oversample tick.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    done       = 1'b0;
    ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next = par_bad_reg;
    perr_next    = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (!rx_sync_reg) begin
          state_next = ST_START;
          s_next     = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (s_reg == 4'd7) begin
            // Mid start bit: a high line means the edge was a glitch.
            if (!rx_sync_reg) begin
              state_next = ST_DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s_reg == 4'd15) begin
            s_next = '0;
            b_next = {rx_sync_reg, b_reg[DBIT-1:1]};
            if (n_reg == NW'(DBIT - 1))
              state_next = ST_AFTER_DATA;
            else
              n_next = n_reg + 1'b1;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (s_reg == 4'd15) begin
            // Even parity: the parity bit equals the XOR of the data bits.
            par_bad_next = rx_sync_reg ^ (^b_reg);
            s_next       = '0;
            state_next   = ST_STOP;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (s_reg == 4'(SB_TICK - 1)) begin
            state_next = ST_IDLE;
            if (!rx_sync_reg)
              ferr_next = 1'b1;
`ifdef UART_RX_PARITY_EN
            else if (par_bad_reg)
              perr_next = 1'b1;
`endif
            else
              done = 1'b1;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  uart_rx_fifo #(
    .DBIT   (DBIT),
    .FIFO_W (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (done),
    .w_data  (b_reg),
    .rd      (rd_uart),
    .r_data  (r_data),
    .empty   (rx_empty),
    .full    (rx_full),
    .overrun (overrun)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx using a short tick divider so that
// multi-frame sequences stay short. Honors UART_RX_PARITY_EN.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DV = 10;
  localparam int BT = 16 * DV;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rd_uart;
  logic [7:0] r_data;
  logic       rx_empty, rx_full, frame_err, overrun, parity_err;

  always #5 clk = ~clk;

  uart_rx #(.DBIT(8), .SB_TICK(16), .DVSR(DV), .FIFO_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rd_uart    (rd_uart),
    .r_data     (r_data),
    .rx_empty   (rx_empty),
    .rx_full    (rx_full),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  int checks   = 0;
  int failures = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int perr_cnt = 0;

  // Count the cycles each pulse output is high (a one-cycle pulse adds 1).
  always @(negedge clk) begin
    if (frame_err)  ferr_cnt <= ferr_cnt + 1;
    if (overrun)    ovr_cnt  <= ovr_cnt + 1;
    if (parity_err) perr_cnt <= perr_cnt + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         ferr;
    int         ovr;
    logic       empty;
    logic       full;
    logic [7:0] head;
    logic       pop;
  } vec_t;

  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s value=0x%0h", name, act);
    end
  endtask

  // One frame, LSB first. A bad stop bit is held low only past its sample
  // point so the line is high again when the receiver re-checks a start.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic par_bad);
    @(negedge clk);
    rx = 1'b0;
    repeat (BT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_bad;
    repeat (BT) @(negedge clk);
`else
    if (par_bad) rx = 1'b1;
`endif
    if (stop_ok) begin
      rx = 1'b1;
      repeat (BT) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (10 * DV) @(negedge clk);
      rx = 1'b1;
      repeat (BT - 10 * DV) @(negedge clk);
    end
  endtask

  task automatic pop();
    @(negedge clk);
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
  endtask

  initial begin
    int lat;
    int f0, o0, p0;

    //                data   stop  ferr ovr empty full head   pop
    vt[0] = '{8'h55, 1'b0, 1,   0,  1'b1, 1'b0, 8'h00, 1'b0};
    vt[1] = '{8'h41, 1'b1, 0,   0,  1'b0, 1'b0, 8'h41, 1'b1};
    vt[2] = '{8'h01, 1'b1, 0,   0,  1'b0, 1'b0, 8'h01, 1'b0};
    vt[3] = '{8'h02, 1'b1, 0,   0,  1'b0, 1'b0, 8'h01, 1'b0};
    vt[4] = '{8'h03, 1'b1, 0,   0,  1'b0, 1'b0, 8'h01, 1'b0};
    vt[5] = '{8'h04, 1'b1, 0,   0,  1'b0, 1'b1, 8'h01, 1'b0};
    vt[6] = '{8'h05, 1'b1, 0,   1,  1'b0, 1'b1, 8'h01, 1'b0};

    reset   = 1'b1;
    rx      = 1'b1;
    rd_uart = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_r_data",     32'(r_data),     32'h00);
    check("rst_rx_empty",   32'(rx_empty),   32'h1);
    check("rst_rx_full",    32'(rx_full),    32'h0);
    check("rst_frame_err",  32'(frame_err),  32'h0);
    check("rst_overrun",    32'(overrun),    32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    reset = 1'b0;
    repeat (BT) @(negedge clk);

    // Single frame: byte lands about 9.5 bit times after the start edge.
    lat = 0;
    fork
      send_frame(8'h41, 1'b1, 1'b0);
      begin
        @(negedge clk);
        while (rx_empty && lat < 3000) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("single_latency_ok", 32'((lat >= 1505) && (lat <= 1535)), 32'h1);
    check("single_empty", 32'(rx_empty), 32'h0);
    check("single_head",  32'(r_data),   32'h41);
    pop();
    check("single_pop_empty", 32'(rx_empty), 32'h1);

    // Back-to-back frames, then two reads.
    send_frame(8'h41, 1'b1, 1'b0);
    send_frame(8'h42, 1'b1, 1'b0);
    repeat (BT) @(negedge clk);
    check("b2b_head0", 32'(r_data),  32'h41);
    check("b2b_full",  32'(rx_full), 32'h0);
    pop();
    check("b2b_head1", 32'(r_data), 32'h42);
    pop();
    check("b2b_empty", 32'(rx_empty), 32'h1);

    // Short low glitch on an idle line must be rejected.
    f0 = ferr_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (4 * DV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BT) @(negedge clk);
    check("glitch_ferr",  32'(ferr_cnt - f0), 32'h0);
    check("glitch_empty", 32'(rx_empty),      32'h1);
    check("glitch_idle",  32'(dut.state_reg), 32'(ST_IDLE));

    // Reset in the middle of a frame leaves no partial byte.
    @(negedge clk);
    rx = 1'b0;
    repeat (5 * BT) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rx = 1'b1;
    repeat (12 * BT) @(negedge clk);
    check("midrst_empty", 32'(rx_empty), 32'h1);

    // Table: framing error, recovery, then fill and overflow the FIFO.
    for (int i = 0; i < 7; i++) begin
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      send_frame(vt[i].data, vt[i].stop_ok, 1'b0);
      repeat (BT) @(negedge clk);
      check($sformatf("vec%0d_ferr", i),  32'(ferr_cnt - f0), 32'(vt[i].ferr));
      check($sformatf("vec%0d_ovr", i),   32'(ovr_cnt - o0),  32'(vt[i].ovr));
      check($sformatf("vec%0d_empty", i), 32'(rx_empty),      32'(vt[i].empty));
      check($sformatf("vec%0d_full", i),  32'(rx_full),       32'(vt[i].full));
      check($sformatf("vec%0d_head", i),  32'(r_data),        32'(vt[i].head));
      if (vt[i].pop) pop();
    end

    // Drain: the dropped 0x05 must not appear.
    for (int i = 2; i <= 4; i++) begin
      pop();
      check($sformatf("drain_head%0d", i), 32'(r_data), 32'(i));
    end
    pop();
    check("drain_empty", 32'(rx_empty), 32'h1);

    // Read on empty is ignored; pointers stay consistent.
    pop();
    check("rd_empty_empty", 32'(rx_empty), 32'h1);
    check("rd_empty_full",  32'(rx_full),  32'h0);
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (BT) @(negedge clk);
    check("after_rd_empty_head", 32'(r_data), 32'h5A);
    pop();
    check("after_rd_empty_empty", 32'(rx_empty), 32'h1);

`ifdef UART_RX_PARITY_EN
    p0 = perr_cnt;
    f0 = ferr_cnt;
    send_frame(8'h41, 1'b1, 1'b1);
    repeat (BT) @(negedge clk);
    check("par_bad_perr",  32'(perr_cnt - p0), 32'h1);
    check("par_bad_ferr",  32'(ferr_cnt - f0), 32'h0);
    check("par_bad_empty", 32'(rx_empty),      32'h1);
    p0 = perr_cnt;
    send_frame(8'h41, 1'b1, 1'b0);
    repeat (BT) @(negedge clk);
    check("par_good_perr", 32'(perr_cnt - p0), 32'h0);
    check("par_good_head", 32'(r_data),        32'h41);
    pop();
`else
    p0 = 0;
    check("parity_err_never", 32'(perr_cnt), 32'(p0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
